// File: rtl/uart_mgr_ng.sv
// uart_mgr_ng: byte-interface UART manager with TX/RX circular buffers,
// level reporting, flush, sticky RX overrun, threshold/TX-done interrupt,
// internal loopback and TX enable gating. 8N1 serial, LSB first; one bit
// lasts baudrate_cfg+1 clocks (baudrate_cfg >= 1 for a valid mid-bit sample).
module uart_mgr_ng #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int LVL_W    = $clog2(((TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH) + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             uart_wr_en,
    input  logic [7:0]       uart_wr_data,
    output logic             uart_wr_ready,
    input  logic             uart_rd_req,
    output logic [7:0]       uart_rd_data,
    output logic             uart_rd_valid,
    output logic [LVL_W-1:0] tx_level,
    output logic [LVL_W-1:0] rx_level,
    input  logic             tx_flush,
    input  logic             rx_flush,
    input  logic             cfg_tx_en,
    input  logic             cfg_loopback,
    input  logic [LVL_W-1:0] cfg_rx_thresh,
    input  logic             cfg_txdone_ie,
    input  logic             clr_overrun,
    output logic             rx_overrun,
    output logic             irq,
    input  logic [7:0]       baudrate_cfg,
    input  logic             rx,
    output logic             tx
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam logic [LVL_W-1:0] TX_FULL = LVL_W'(TX_DEPTH);
    localparam logic [LVL_W-1:0] RX_FULL = LVL_W'(RX_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    typedef enum logic       {TX_IDLE, TX_RUN} tx_st_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TPW-1:0]   tx_wp_q, tx_rp_q;
    logic [RPW-1:0]   rx_wp_q, rx_rp_q;
    logic [LVL_W-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic             issued_q, rx_overrun_q, irq_q, rx_s1_q, rx_s2_q;

    tx_st_e           tx_st_q, tx_st_d;
    logic [9:0]       tx_sh_q, tx_sh_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_cnt_q, tx_cnt_d;
    rx_st_e           rx_st_q, rx_st_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_cnt_q, rx_cnt_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_valid, rx_pop, rx_wr, ovr;
    logic tx_busy, tx_line, rin, urx_valid;

    assign tx_full  = (tx_lvl_q == TX_FULL);
    assign tx_empty = (tx_lvl_q == '0);
    assign rx_full  = (rx_lvl_q == RX_FULL);
    assign rx_empty = (rx_lvl_q == '0);
    assign tx_busy  = (tx_st_q == TX_RUN);
    assign tx_line  = tx_busy ? tx_sh_q[0] : 1'b1;
    assign rin      = cfg_loopback ? tx_line : rx_s2_q;

    // issued_q blocks back-to-back issues, covering busy that rises a cycle after issue
    assign tx_push  = uart_wr_en & ~tx_full & ~tx_flush;
    assign tx_valid = cfg_tx_en & ~tx_empty & ~tx_busy & ~issued_q & ~tx_flush;
    assign rx_pop   = uart_rd_req & ~rx_empty & ~rx_flush;
    assign rx_wr    = urx_valid & (~rx_full | rx_pop) & ~rx_flush;
    assign ovr      = urx_valid & rx_full & ~rx_pop & ~rx_flush;

    assign uart_wr_ready = ~tx_full;
    assign uart_rd_valid = ~rx_empty;
    assign uart_rd_data  = rx_mem[rx_rp_q];
    assign tx_level      = tx_lvl_q;
    assign rx_level      = rx_lvl_q;
    assign rx_overrun    = rx_overrun_q;
    assign irq           = irq_q;
    assign tx            = cfg_loopback ? 1'b1 : tx_line;

    // Buffer levels: flush wins, simultaneous push and pop leave the level unchanged
    always_comb begin
        tx_lvl_d = tx_lvl_q;
        rx_lvl_d = rx_lvl_q;
        if (tx_flush)                tx_lvl_d = '0;
        else if (tx_push && !tx_valid) tx_lvl_d = tx_lvl_q + LVL_ONE;
        else if (!tx_push && tx_valid) tx_lvl_d = tx_lvl_q - LVL_ONE;
        if (rx_flush)                rx_lvl_d = '0;
        else if (rx_wr && !rx_pop)   rx_lvl_d = rx_lvl_q + LVL_ONE;
        else if (!rx_wr && rx_pop)   rx_lvl_d = rx_lvl_q - LVL_ONE;
    end

    // Serializer next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q;
        unique case (tx_st_q)
            TX_IDLE: if (tx_valid) begin
                tx_st_d  = TX_RUN;
                tx_sh_d  = {1'b1, tx_mem[tx_rp_q], 1'b0};
                tx_bit_d = '0;
                tx_cnt_d = '0;
            end
            TX_RUN: if (tx_cnt_q == baudrate_cfg) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) tx_st_d = TX_IDLE;
                else begin
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else tx_cnt_d = tx_cnt_q + 8'd1;
            default: tx_st_d = TX_IDLE;
        endcase
    end

    // Deserializer next state: confirm start at mid-bit, then sample every bit time
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_sh_d   = rx_sh_q;
        rx_bit_d  = rx_bit_q;
        rx_cnt_d  = rx_cnt_q;
        urx_valid = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: if (!rin) begin
                rx_st_d  = RX_START;
                rx_cnt_d = '0;
            end
            RX_START: if (rx_cnt_q == (baudrate_cfg >> 1)) begin
                rx_st_d  = rin ? RX_IDLE : RX_DATA;
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end else rx_cnt_d = rx_cnt_q + 8'd1;
            RX_DATA: if (rx_cnt_q == baudrate_cfg) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rin, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q + 8'd1;
            RX_STOP: if (rx_cnt_q == baudrate_cfg) begin
                rx_st_d   = RX_IDLE;
                urx_valid = rin;
            end else rx_cnt_d = rx_cnt_q + 8'd1;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // Buffer storage, no reset needed: contents are only read when level says valid
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= uart_wr_data;
        if (rx_wr)   rx_mem[rx_wp_q] <= rx_sh_q;
    end

    // Control state: pointers, levels, serial engines, sticky flag, registered irq
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
            tx_lvl_q <= '0; rx_lvl_q <= '0;
            issued_q <= 1'b0; rx_overrun_q <= 1'b0; irq_q <= 1'b0;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1;
            tx_st_q <= TX_IDLE; tx_sh_q <= '1; tx_bit_q <= '0; tx_cnt_q <= '0;
            rx_st_q <= RX_IDLE; rx_sh_q <= '0; rx_bit_q <= '0; rx_cnt_q <= '0;
        end else begin
            if (tx_flush) begin
                tx_wp_q <= '0; tx_rp_q <= '0;
            end else begin
                if (tx_push)  tx_wp_q <= tx_wp_q + TPW'(1);
                if (tx_valid) tx_rp_q <= tx_rp_q + TPW'(1);
            end
            if (rx_flush) begin
                rx_wp_q <= '0; rx_rp_q <= '0;
            end else begin
                if (rx_wr)  rx_wp_q <= rx_wp_q + RPW'(1);
                if (rx_pop) rx_rp_q <= rx_rp_q + RPW'(1);
            end
            tx_lvl_q <= tx_lvl_d;
            rx_lvl_q <= rx_lvl_d;
            issued_q <= tx_valid;
            if (ovr)              rx_overrun_q <= 1'b1;
            else if (clr_overrun) rx_overrun_q <= 1'b0;
            irq_q <= ((cfg_rx_thresh != '0) && (rx_lvl_q >= cfg_rx_thresh))
                   || (cfg_txdone_ie && tx_empty && !tx_busy && !tx_valid)
                   || rx_overrun_q;
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            tx_st_q <= tx_st_d; tx_sh_q <= tx_sh_d; tx_bit_q <= tx_bit_d; tx_cnt_q <= tx_cnt_d;
            rx_st_q <= rx_st_d; rx_sh_q <= rx_sh_d; rx_bit_q <= rx_bit_d; rx_cnt_q <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_mgr_ng.sv
// Directed bench for uart_mgr_ng: scoreboard queues of expected TX frames and
// RX bytes, a serial monitor decoding the tx pin, immediate-assertion checks.
module tb_uart_mgr_ng;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0, rstb = 1'b0;
    logic          uart_wr_en = 1'b0, uart_rd_req = 1'b0;
    logic [7:0]    uart_wr_data = '0, uart_rd_data, baudrate_cfg = 8'd3;
    logic          uart_wr_ready, uart_rd_valid, rx_overrun, irq, tx;
    logic [LW-1:0] tx_level, rx_level, cfg_rx_thresh = '0;
    logic          tx_flush = 1'b0, rx_flush = 1'b0, cfg_tx_en = 1'b0, cfg_loopback = 1'b0;
    logic          cfg_txdone_ie = 1'b0, clr_overrun = 1'b0, rx = 1'b1;

    int n_vec = 0, n_err = 0;
    int bitc = 4;          // clocks per serial bit, tracks baudrate_cfg+1
    bit mon_en = 1'b0;
    int frame_err = 0;
    logic [7:0] tx_exp[$], tx_obs[$], rx_exp[$];

    uart_mgr_ng #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rstb(rstb),
        .uart_wr_en(uart_wr_en), .uart_wr_data(uart_wr_data), .uart_wr_ready(uart_wr_ready),
        .uart_rd_req(uart_rd_req), .uart_rd_data(uart_rd_data), .uart_rd_valid(uart_rd_valid),
        .tx_level(tx_level), .rx_level(rx_level), .tx_flush(tx_flush), .rx_flush(rx_flush),
        .cfg_tx_en(cfg_tx_en), .cfg_loopback(cfg_loopback), .cfg_rx_thresh(cfg_rx_thresh),
        .cfg_txdone_ie(cfg_txdone_ie), .clr_overrun(clr_overrun), .rx_overrun(rx_overrun),
        .irq(irq), .baudrate_cfg(baudrate_cfg), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Serial monitor: decode 8N1 frames on the tx pin, sampling mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (bitc / 2) @(negedge clk);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (bitc) @(negedge clk);
                    b[i] = tx;
                end
                repeat (bitc) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                tx_obs.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        uart_wr_en = 1'b1; uart_wr_data = d;
        @(negedge clk);
        uart_wr_en = 1'b0;
    endtask

    task automatic pop();
        uart_rd_req = 1'b1;
        @(negedge clk);
        uart_rd_req = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int g, lat;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_txlvl", 32'(tx_level), 0);
        check("rst_rxlvl", 32'(rx_level), 0);
        check("rst_wrrdy", 32'(uart_wr_ready), 1);
        check("rst_rdvld", 32'(uart_rd_valid), 0);
        check("rst_irq",   32'(irq), 0);
        check("rst_ovr",   32'(rx_overrun), 0);
        check("rst_tx",    32'(tx), 1);
        rstb = 1'b1;
        @(negedge clk);

        // 1: reset in the middle of a transmission with bytes queued
        cfg_tx_en = 1'b1; cfg_txdone_ie = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (10) @(negedge clk);
        rstb = 1'b0;
        #1;
        check("t1_txlvl", 32'(tx_level), 0);
        check("t1_rxlvl", 32'(rx_level), 0);
        check("t1_tx",    32'(tx), 1);
        check("t1_irq",   32'(irq), 0);
        @(negedge clk);
        rstb = 1'b1;
        cfg_txdone_ie = 1'b0;
        repeat (60) @(negedge clk);
        check("t1_idle_tx", 32'(tx), 1);
        tx_obs.delete();
        mon_en = 1'b1;

        // 2: overfill with drain disabled, then release
        cfg_tx_en = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            d = 8'(i * 29 + 3);
            push(d);
            if (i < DEPTH) tx_exp.push_back(d);
        end
        check("t2_txlvl", 32'(tx_level), DEPTH);
        check("t2_wrrdy", 32'(uart_wr_ready), 0);
        cfg_tx_en = 1'b1;
        g = 0;
        while (tx_obs.size() < DEPTH && g < 3000) begin @(negedge clk); g++; end
        check("t2_nframes", 32'(tx_obs.size()), DEPTH);
        while (tx_obs.size() > 0 && tx_exp.size() > 0)
            check("t2_frame", 32'(tx_obs.pop_front()), 32'(tx_exp.pop_front()));
        repeat (60) @(negedge clk);
        check("t2_extra", 32'(tx_obs.size()), 0);
        check("t2_txlvl_end", 32'(tx_level), 0);
        check("t2_wrrdy_end", 32'(uart_wr_ready), 1);

        // 3: loopback pair with RX threshold interrupt
        cfg_loopback = 1'b1; baudrate_cfg = 8'd9; bitc = 10; cfg_rx_thresh = 5'd2;
        @(negedge clk);
        push(8'h55); rx_exp.push_back(8'h55);
        push(8'hA3); rx_exp.push_back(8'hA3);
        g = 0;
        while (rx_level != 5'd2 && g < 2000) begin
            @(negedge clk); g++;
            if (rx_level < 5'd2 && irq !== 1'b0) check("t3_irq_early", 32'(irq), 0);
        end
        check("t3_rxlvl", 32'(rx_level), 2);
        check("t3_irq_lat0", 32'(irq), 0);
        @(negedge clk);
        check("t3_irq_lat1", 32'(irq), 1);
        check("t3_tx_held", 32'(tx), 1);
        for (int i = 0; i < 2; i++) begin
            check("t3_rdvld", 32'(uart_rd_valid), 1);
            check("t3_rddata", 32'(uart_rd_data), 32'(rx_exp.pop_front()));
            pop();
        end
        check("t3_empty", 32'(uart_rd_valid), 0);
        cfg_rx_thresh = '0;
        repeat (2) @(negedge clk);
        check("t3_irq_off", 32'(irq), 0);

        // 4: loopback overrun, DEPTH+1 bytes with no pops
        baudrate_cfg = 8'd3; bitc = 4;
        repeat (20) @(negedge clk);
        push(8'hE0); rx_exp.push_back(8'hE0);
        lat = 0;
        while (rx_level != 5'd1 && lat < 500) begin @(negedge clk); lat++; end
        check("t4_first", 32'(rx_level), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            d = 8'(8'hE0 + i * 5);
            push(d);
            if (i < DEPTH) rx_exp.push_back(d);
        end
        g = 0;
        while (rx_overrun !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
        check("t4_ovr", 32'(rx_overrun), 1);
        check("t4_rxlvl", 32'(rx_level), DEPTH);
        @(negedge clk);
        check("t4_irq", 32'(irq), 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("t4_ovr_clr", 32'(rx_overrun), 0);

        // 5: RX full, pop lands in the same cycle the received byte is written
        repeat (10) @(negedge clk);
        push(8'hC7);
        repeat (lat - 1) @(negedge clk);
        check("t5_head", 32'(uart_rd_data), 32'(rx_exp.pop_front()));
        pop();
        rx_exp.push_back(8'hC7);
        check("t5_ovr", 32'(rx_overrun), 0);
        check("t5_rxlvl", 32'(rx_level), DEPTH);
        repeat (10) @(negedge clk);
        check("t5_ovr_late", 32'(rx_overrun), 0);
        for (int i = 0; i < DEPTH; i++) begin
            check("t5_rddata", 32'(uart_rd_data), 32'(rx_exp.pop_front()));
            pop();
        end
        check("t5_empty", 32'(uart_rd_valid), 0);

        // 6: flush mid-frame, TX-done interrupt after stop bit
        cfg_loopback = 1'b0;
        repeat (10) @(negedge clk);
        tx_obs.delete();
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'h3C ^ (i * 17));
            push(d);
            if (i == 0) tx_exp.push_back(d);
        end
        check("t6_txlvl", 32'(tx_level), 5);
        repeat (8) @(negedge clk);
        tx_flush = 1'b1;
        @(negedge clk);
        tx_flush = 1'b0;
        check("t6_flushed", 32'(tx_level), 0);
        cfg_txdone_ie = 1'b1;
        @(negedge clk);
        check("t6_irq_busy", 32'(irq), 0);
        g = 0;
        while (irq !== 1'b1 && g < 500) begin @(negedge clk); g++; end
        check("t6_irq", 32'(irq), 1);
        check("t6_tx_idle", 32'(tx), 1);
        repeat (100) @(negedge clk);
        check("t6_nframes", 32'(tx_obs.size()), 1);
        if (tx_obs.size() > 0 && tx_exp.size() > 0)
            check("t6_frame", 32'(tx_obs.pop_front()), 32'(tx_exp.pop_front()));
        check("framing", 32'(frame_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
